// File: rtl/ffd_piso_tx.sv
// Parallel-in/serial-out transmitter: captures a WIDTH-bit word on valid/ready, shifts it out LSB-first.
// Latency: first bit on sdo one enabled cycle after accept; frame = WIDTH bits (+1 parity bit).
// Backpressure: in_ready only in IDLE with en=1; en=0 freezes all state. Optional parity bit: define PARITY_EN.
module ffd_piso_tx #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             sdo,
  output logic             sdo_valid,
  output logic             sdo_last
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
`ifdef PARITY_EN
    PAR   = 2'd2,
`endif
    IDLE  = 2'd0,
    SHIFT = 2'd1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    cnt;
  logic             load;
  logic             shift;
  logic             last_bit;
`ifdef PARITY_EN
  logic             par;
`endif

  // cnt counts data bits already sent; the final data bit is on sdo when cnt hits WIDTH-1
  assign last_bit = (cnt == CW'(WIDTH - 1));
  assign in_ready = (state == IDLE) && en;

  // Next-state decode; load/shift strobes only fire on enabled cycles
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift     = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && en) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (en) begin
          shift = 1'b1;
          if (last_bit) begin
`ifdef PARITY_EN
            state_nxt = PAR;
`else
            state_nxt = IDLE;
`endif
          end
        end
      end
`ifdef PARITY_EN
      PAR: begin
        if (en) state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset wins over en and aborts any frame in flight
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Datapath: capture on accept, shift right with zero fill; cnt returns to 0 instead of passing WIDTH-1
  always_ff @(posedge clk) begin
    if (!reset) begin
      sr  <= '0;
      cnt <= '0;
`ifdef PARITY_EN
      par <= 1'b0;
`endif
    end else if (load) begin
      sr  <= din;
      cnt <= '0;
`ifdef PARITY_EN
      par <= ^din;
`endif
    end else if (shift) begin
      sr  <= sr >> 1;
      cnt <= last_bit ? '0 : cnt + CW'(1);
    end
  end

  // Outputs decode from flops only, so a stalled bit is simply held on the line
  always_comb begin
    sdo       = 1'b0;
    sdo_valid = 1'b0;
    sdo_last  = 1'b0;
    case (state)
      SHIFT: begin
        sdo       = sr[0];
        sdo_valid = 1'b1;
`ifndef PARITY_EN
        sdo_last  = last_bit;
`endif
      end
`ifdef PARITY_EN
      PAR: begin
        sdo       = par;
        sdo_valid = 1'b1;
        sdo_last  = 1'b1;
      end
`endif
      default: begin
        sdo       = 1'b0;
        sdo_valid = 1'b0;
        sdo_last  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ffd_piso_tx.sv
// Directed bench for ffd_piso_tx (WIDTH=4); expected serial streams are hand-derived from the words sent.
// Inputs change 1 time unit after each rising edge; outputs are sampled at the same point.
// Works with or without PARITY_EN defined.
module tb_ffd_piso_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [3:0] din;
  logic       in_valid;
  logic       in_ready;
  logic       sdo;
  logic       sdo_valid;
  logic       sdo_last;

  int n_cmp = 0;
  int n_err = 0;

  ffd_piso_tx #(.WIDTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .din       (din),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sdo       (sdo),
    .sdo_valid (sdo_valid),
    .sdo_last  (sdo_last)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare {sdo, sdo_valid, sdo_last} against expectation
  task automatic chk_out(input string tag, input logic e_sdo, input logic e_vld, input logic e_last);
    chk(tag, {29'd0, sdo, sdo_valid, sdo_last}, {29'd0, e_sdo, e_vld, e_last});
  endtask

  // Called in the first-bit cycle; walks the whole frame and ends in the first IDLE cycle after it
  task automatic check_frame(input string tag, input logic [3:0] w);
    logic e_last;
    for (int i = 0; i < 4; i++) begin
`ifdef PARITY_EN
      e_last = 1'b0;
`else
      e_last = (i == 3);
`endif
      chk_out($sformatf("%s_bit%0d", tag, i), w[i], 1'b1, e_last);
      chk($sformatf("%s_rdy_busy%0d", tag, i), {31'd0, in_ready}, 32'd0);
      tick();
    end
`ifdef PARITY_EN
    chk_out($sformatf("%s_parity", tag), ^w, 1'b1, 1'b1);
    tick();
`endif
    chk_out($sformatf("%s_idle", tag), 1'b0, 1'b0, 1'b0);
    chk($sformatf("%s_rdy_idle", tag), {31'd0, in_ready}, {31'd0, en});
  endtask

  initial begin
    reset    = 1'b0;
    en       = 1'b1;
    din      = 4'd0;
    in_valid = 1'b0;
    tick();
    tick();
    // reset state
    chk_out("reset_out", 1'b0, 1'b0, 1'b0);
    chk("reset_rdy", {31'd0, in_ready}, 32'd1);
    reset = 1'b1;
    tick();

    // Test 1: 1011 -> 1,1,0,1
    din = 4'b1011; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; din = 4'd0;
    check_frame("t1", 4'b1011);

    // Test 2: 0011 (parity bit 0 when enabled)
    din = 4'b0011; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check_frame("t2", 4'b0011);

    // Test 3: stall 3 cycles while the 2nd bit is on sdo
    din = 4'b1011; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk_out("t3_bit0", 1'b1, 1'b1, 1'b0);
    tick();
    chk_out("t3_bit1", 1'b1, 1'b1, 1'b0);
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_out($sformatf("t3_hold%0d", k), 1'b1, 1'b1, 1'b0);
      chk($sformatf("t3_rdy_hold%0d", k), {31'd0, in_ready}, 32'd0);
    end
    en = 1'b1;
    tick();
`ifdef PARITY_EN
    chk_out("t3_bit2", 1'b0, 1'b1, 1'b0);
    tick();
    chk_out("t3_bit3", 1'b1, 1'b1, 1'b0);
    tick();
    chk_out("t3_parity", 1'b1, 1'b1, 1'b1);
`else
    chk_out("t3_bit2", 1'b0, 1'b1, 1'b0);
    tick();
    chk_out("t3_bit3", 1'b1, 1'b1, 1'b1);
`endif
    tick();
    chk_out("t3_idle", 1'b0, 1'b0, 1'b0);

    // Test 4: reset during the 3rd bit, then a fresh word 0110 -> 0,1,1,0
    din = 4'b1011; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk_out("t4_bit2", 1'b0, 1'b1, 1'b0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk_out("t4_abort", 1'b0, 1'b0, 1'b0);
    chk("t4_rdy", {31'd0, in_ready}, 32'd1);
    din = 4'b0110; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check_frame("t4", 4'b0110);

    // Test 5: 1111 held valid throughout frame 0001; accepted in first IDLE cycle
    din = 4'b0001; in_valid = 1'b1;
    tick();
    din = 4'b1111;
    check_frame("t5a", 4'b0001);
    tick();
    in_valid = 1'b0;
    check_frame("t5b", 4'b1111);

    // Test 6: en=0 in IDLE blocks capture; en=1 captures on that edge
    en = 1'b0; din = 4'b0101; in_valid = 1'b1;
    #1;
    chk("t6_rdy_off", {31'd0, in_ready}, 32'd0);
    tick();
    tick();
    chk_out("t6_nocap", 1'b0, 1'b0, 1'b0);
    en = 1'b1;
    #1;
    chk("t6_rdy_on", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check_frame("t6", 4'b0101);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
